pbpix_zrle_tx: RTL

Transmitter end of the pbpix pixel interface. Consumes a zero-run-length token stream (rdy/ack) from the feature-map buffer read port and expands it into a one-pixel-per-handshake pbpix stream with `_zero` flags, frame-last marking and a sticky error flag. Sits between on-chip compressed storage and any pbpix receiver (PE array input). Sustains one pixel per cycle when the downstream acks every cycle.

---
 rtl/pbpix_zrle_tx.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pbpix_zrle_tx.sv
// pbpix_zrle_tx
// Expands a zero-run-length token stream into a one-pixel-per-handshake
// pbpix stream.
//
// Parameters
//   DW   : pixel data width
//   RUNW : run-length field width (runs of 1 .. 2^RUNW-1 zeros)
//   NPIX : pixels per frame (>= 2), drives pix_last
// Ports
//   i_clk, i_rstn : clock (rising edge), synchronous active-low reset
//   tok_rdy/tok_ack/tok_run/tok_data : token input (rdy/ack handshake)
//   pix_rdy/pix_ack/pix_zero/pix_data/pix_last : pbpix pixel output
//   err : sticky flag, set when a zero-length run token is consumed
//
// Operating modes are implied by the output register and the run counter:
// IDLE (pix_rdy=0), HOLD (pix_rdy=1, rem=0), RUN (pix_rdy=1, rem>0).
module pbpix_zrle_tx #(
   parameter int DW   = 16,
   parameter int RUNW = 8,
   parameter int NPIX = 64
) (
   input  logic          i_clk,
   input  logic          i_rstn,
   input  logic          tok_rdy,
   output logic          tok_ack,
   input  logic          tok_run,
   input  logic [DW-1:0] tok_data,
   output logic          pix_rdy,
   input  logic          pix_ack,
   output logic          pix_zero,
   output logic [DW-1:0] pix_data,
   output logic          pix_last,
   output logic          err
);

   localparam int            CW       = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(NPIX - 1);

   logic            pix_rdy_q,  pix_rdy_d;
   logic            pix_zero_q, pix_zero_d;
   logic [DW-1:0]   pix_data_q, pix_data_d;
   logic            pix_last_q, pix_last_d;
   logic            err_q,      err_d;
   logic [RUNW-1:0] rem_q,      rem_d;
   logic [CW-1:0]   cnt_q,      cnt_d;

   logic            free_s;
   logic            hs_s;
   logic            tok_ack_s;
   logic [RUNW-1:0] run_len_s;
   logic            last_nxt_s;

   // Handshake decode and frame position of the pixel that would load this edge.
   always_comb begin
      run_len_s = tok_data[RUNW-1:0];
      free_s    = !pix_rdy_q || pix_ack;
      hs_s      = pix_rdy_q && pix_ack;
      // A token may only be taken once the current run has no zeros left
      // and the output slot frees up this cycle; never during reset.
      tok_ack_s = i_rstn && tok_rdy && (rem_q == {RUNW{1'b0}}) && free_s;
      if (hs_s) begin
         if (cnt_q == LAST_IDX) begin
            cnt_d = {CW{1'b0}};
         end else begin
            cnt_d = cnt_q + CW'(1'b1);
         end
      end else begin
         cnt_d = cnt_q;
      end
      // cnt_d is the index of whatever pixel sits in the register after the edge.
      last_nxt_s = (cnt_d == LAST_IDX);
   end

   // Next-state for the output register, run counter and error flag.
   always_comb begin
      pix_rdy_d  = pix_rdy_q;
      pix_zero_d = pix_zero_q;
      pix_data_d = pix_data_q;
      pix_last_d = pix_last_q;
      rem_d      = rem_q;
      err_d      = err_q;
      if (tok_ack_s && !tok_run) begin
         // Literal token: a literal 0 is still emitted, flagged as zero.
         pix_rdy_d  = 1'b1;
         pix_data_d = tok_data;
         pix_zero_d = (tok_data == {DW{1'b0}});
         pix_last_d = last_nxt_s;
      end else if (tok_ack_s && (run_len_s != {RUNW{1'b0}})) begin
         // First zero of the run goes out now, the rest are counted in rem.
         pix_rdy_d  = 1'b1;
         pix_data_d = {DW{1'b0}};
         pix_zero_d = 1'b1;
         pix_last_d = last_nxt_s;
         rem_d      = run_len_s - RUNW'(1'b1);
      end else if (hs_s && (rem_q != {RUNW{1'b0}})) begin
         pix_rdy_d  = 1'b1;
         pix_data_d = {DW{1'b0}};
         pix_zero_d = 1'b1;
         pix_last_d = last_nxt_s;
         rem_d      = rem_q - RUNW'(1'b1);
      end else if (hs_s) begin
         // Pixel retired with nothing to replace it (includes the L=0 case).
         pix_rdy_d = 1'b0;
      end else begin
         pix_rdy_d = pix_rdy_q;
      end
      if (tok_ack_s && tok_run && (run_len_s == {RUNW{1'b0}})) begin
         err_d = 1'b1;
      end else begin
         err_d = err_q;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         pix_rdy_q  <= 1'b0;
         pix_zero_q <= 1'b0;
         pix_data_q <= {DW{1'b0}};
         pix_last_q <= 1'b0;
         err_q      <= 1'b0;
         rem_q      <= {RUNW{1'b0}};
         cnt_q      <= {CW{1'b0}};
      end else begin
         pix_rdy_q  <= pix_rdy_d;
         pix_zero_q <= pix_zero_d;
         pix_data_q <= pix_data_d;
         pix_last_q <= pix_last_d;
         err_q      <= err_d;
         rem_q      <= rem_d;
         cnt_q      <= cnt_d;
      end
   end

   assign tok_ack  = tok_ack_s;
   assign pix_rdy  = pix_rdy_q;
   assign pix_zero = pix_zero_q;
   assign pix_data = pix_data_q;
   assign pix_last = pix_last_q;
   assign err      = err_q;

endmodule
